mod_reduce_64: RTL



---
 rtl/bfftp_pkg.sv | 14 +
 rtl/mod_canon_64.sv | 12 +
 rtl/mod_reduce_64.sv | 95 +++++++++
 3 files changed

// File: rtl/bfftp_pkg.sv
// Shared constants for the BFFTP butterfly datapath (Goldilocks field, P = 2^64 - 2^32 + 1).
package bfftp_pkg;

    localparam int          P_WIDTH  = 64;
    localparam int          PD_WIDTH = 128;
    localparam logic [63:0] MOD_P    = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] EPSILON  = 64'h0000_0000_FFFF_FFFF;

    // x * EPSILON for a 32-bit x, as a shift-and-subtract; exact in 64 bits.
    function automatic logic [63:0] mul_eps(input logic [31:0] x);
        return {x, 32'h0} - {32'h0, x};
    endfunction

endpackage

// File: rtl/mod_canon_64.sv
// Final canonicalisation for values already below 2P: subtracts P once when needed.
// Purely combinational; shared with the downstream modular adder.
module mod_canon_64
    import bfftp_pkg::*;
(
    input  logic [P_WIDTH-1:0] x,
    output logic [P_WIDTH-1:0] y
);

    assign y = (x >= MOD_P) ? (x - MOD_P) : x;

endmodule

// File: rtl/mod_reduce_64.sv
// 128-bit product -> canonical residue mod P; latency 2 enabled cycles (3 with MODRED_PIPE3_EN).
// No back-pressure: en=0 freezes every register including valid bits.
module mod_reduce_64
    import bfftp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [PD_WIDTH-1:0] in_data,
    output logic                out_valid,
    output logic [P_WIDTH-1:0]  out_data
);

    logic [63:0] x_lo;
    logic [31:0] x_hl;
    logic [31:0] x_hh;
    logic [63:0] diff;
    logic        borrow;
    logic [63:0] t0_next;
    logic [63:0] t1_next;

    logic [63:0] t0;
    logic [63:0] t1;
    logic        v1;

    logic [64:0] s;
    logic [63:0] r;
    logic [63:0] canon_in;
    logic [63:0] canon_out;

    assign x_lo = in_data[63:0];
    assign x_hl = in_data[95:64];
    assign x_hh = in_data[127:96];

    // x_hh * 2^96 == -x_hh; a borrow means we added 2^64, which is worth EPSILON.
    assign diff    = x_lo - {32'h0, x_hh};
    assign borrow  = x_lo < {32'h0, x_hh};
    assign t0_next = borrow ? (diff - EPSILON) : diff;
    assign t1_next = mul_eps(x_hl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0 <= '0;
            t1 <= '0;
            v1 <= 1'b0;
        end else if (en) begin
            t0 <= t0_next;
            t1 <= t1_next;
            v1 <= in_valid;
        end
    end

    // A carry out of bit 64 is again worth EPSILON; the sum then cannot overflow again.
    assign s = {1'b0, t0} + {1'b0, t1};
    assign r = s[64] ? (s[63:0] + EPSILON) : s[63:0];

`ifdef MODRED_PIPE3_EN
    logic [63:0] r_q;
    logic        v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            v2  <= 1'b0;
        end else if (en) begin
            r_q <= r;
            v2  <= v1;
        end
    end

    assign canon_in = r_q;
`else
    logic v2;

    assign v2       = v1;
    assign canon_in = r;
`endif

    mod_canon_64 u_canon (
        .x (canon_in),
        .y (canon_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_data  <= canon_out;
            out_valid <= v2;
        end
    end

endmodule
